// File: rtl/sqrt_display_pkg.sv
// ---------------------------------------------------------------------------
// sqrt_display_pkg
// Shared types and constants for the square-root result display.
//   state_t   : capture/convert/commit/show controller states
//   SEG_DASH  : active-low pattern with only segment g lit
//   SEG_BLANK : active-low pattern with every segment off
//   dd_adjust : double-dabble "add 3 if >= 5" correction for one BCD nibble
// ---------------------------------------------------------------------------
package sqrt_display_pkg;

   typedef enum logic [1:0] {
      EMPTY  = 2'd0,
      CONV   = 2'd1,
      COMMIT = 2'd2,
      SHOW   = 2'd3
   } state_t;

   // Cathode order is {g,f,e,d,c,b,a}, active-low.
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // One iteration per operand bit.
   localparam int unsigned DD_ITERS = 8;

   function automatic logic [3:0] dd_adjust(input logic [3:0] nib);
      return (nib >= 4'd5) ? (nib + 4'd3) : nib;
   endfunction

endpackage

// File: rtl/seg7_decoder.sv
// ---------------------------------------------------------------------------
// seg7_decoder
// Combinational hex digit to 7-segment pattern (b and d drawn lowercase).
//   hex : digit value 0..F
//   seg : cathodes {g,f,e,d,c,b,a}, active-low
// ---------------------------------------------------------------------------
module seg7_decoder (
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   always_comb begin
      seg = 7'b1111111;
      unique case (hex)
         4'h0: seg = 7'b1000000;
         4'h1: seg = 7'b1111001;
         4'h2: seg = 7'b0100100;
         4'h3: seg = 7'b0110000;
         4'h4: seg = 7'b0011001;
         4'h5: seg = 7'b0010010;
         4'h6: seg = 7'b0000010;
         4'h7: seg = 7'b1111000;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0010000;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b0000011;
         4'hC: seg = 7'b1000110;
         4'hD: seg = 7'b0100001;
         4'hE: seg = 7'b0000110;
         4'hF: seg = 7'b0001110;
      endcase
   end

endmodule

// File: rtl/sqrt_display.sv
// ---------------------------------------------------------------------------
// sqrt_display
// Captures a square-root result on the rising edge of done, converts the
// 8-bit operand to BCD by double-dabble (one bit per cycle), then shows
// sqrt (hex) and the operand (decimal) on a 4-digit multiplexed display.
//   clk   : system clock, rising edge
//   clr   : asynchronous active-low reset
//   done  : result-valid level; its rising edge requests a capture
//   sqrt  : root value 0..15, shown on an[3]
//   a     : operand 0..255, shown on an[2:0] in decimal
//   seg   : cathodes {g,f,e,d,c,b,a}, active-low, registered
//   an    : digit anodes, active-low one-hot, registered
//   dp    : decimal point, active-low, lit on an[3] only, registered
//   busy  : high while a conversion is in progress
// ---------------------------------------------------------------------------
module sqrt_display
   import sqrt_display_pkg::*;
#(
   parameter int DIGIT_CYCLES = 32768
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       done,
   input  logic [3:0] sqrt,
   input  logic [7:0] a,
   output logic [6:0] seg,
   output logic [3:0] an,
   output logic       dp,
   output logic       busy
);

   localparam int CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_CYCLES - 1);
   localparam logic [2:0] ITER_LAST = 3'(DD_ITERS - 1);

   state_t       state;
   logic         done_q;
   logic         capture;

   // working registers
   logic [7:0]   bin_r;
   logic [3:0]   sqrt_r;
   logic [9:0]   bcd_r;
   logic [2:0]   iter_r;
   logic [9:0]   bcd_adj;

   // display registers; disp_valid stays low until the first commit
   logic [1:0]   disp_h;
   logic [3:0]   disp_t;
   logic [3:0]   disp_o;
   logic [3:0]   disp_s;
   logic         disp_valid;

   // scan
   logic [CNT_W-1:0] scan_cnt;
   logic [1:0]   dig_idx;

   // output mux
   logic [3:0]   mux_nib;
   logic         mux_blank;
   logic         mux_dp;
   logic [6:0]   dec_seg;
   logic [6:0]   seg_next;

   // Only EMPTY and SHOW accept a new capture; edges during a conversion
   // are dropped rather than queued.
   assign capture = done & ~done_q & ((state == EMPTY) || (state == SHOW));

   // Hundreds never exceeds 1 before the final shift, so it needs no
   // correction and its top bit falls off harmlessly.
   assign bcd_adj = {bcd_r[9:8], dd_adjust(bcd_r[7:4]), dd_adjust(bcd_r[3:0])};

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state      <= EMPTY;
         done_q     <= 1'b0;
         busy       <= 1'b0;
         bin_r      <= '0;
         sqrt_r     <= '0;
         bcd_r      <= '0;
         iter_r     <= '0;
         disp_h     <= '0;
         disp_t     <= '0;
         disp_o     <= '0;
         disp_s     <= '0;
         disp_valid <= 1'b0;
      end else begin
         done_q <= done;
         case (state)
            EMPTY, SHOW: begin
               if (capture) begin
                  bin_r  <= a;
                  sqrt_r <= sqrt;
                  bcd_r  <= '0;
                  iter_r <= '0;
                  busy   <= 1'b1;
                  state  <= CONV;
               end
            end
            CONV: begin
               {bcd_r, bin_r} <= {bcd_adj[8:0], bin_r, 1'b0};
               iter_r         <= iter_r + 3'd1;
               if (iter_r == ITER_LAST) begin
                  state <= COMMIT;
               end
            end
            COMMIT: begin
               // all four digits change together so no partial result shows
               disp_h     <= bcd_r[9:8];
               disp_t     <= bcd_r[7:4];
               disp_o     <= bcd_r[3:0];
               disp_s     <= sqrt_r;
               disp_valid <= 1'b1;
               busy       <= 1'b0;
               state      <= SHOW;
            end
            default: begin
               state <= EMPTY;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Digit scan runs in every state, independent of conversions.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         scan_cnt <= '0;
         dig_idx  <= 2'd0;
      end else if (scan_cnt == CNT_LAST) begin
         scan_cnt <= '0;
         dig_idx  <= dig_idx + 2'd1;
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
      end
   end

   always_comb begin
      mux_nib   = 4'h0;
      mux_blank = 1'b0;
      mux_dp    = 1'b1;
      case (dig_idx)
         2'd3: begin
            mux_nib = disp_s;
            mux_dp  = 1'b0;
         end
         2'd2: begin
            mux_nib   = {2'b00, disp_h};
            mux_blank = (disp_h == 2'd0);
         end
         2'd1: begin
            mux_nib   = disp_t;
            mux_blank = (disp_h == 2'd0) && (disp_t == 4'd0);
         end
         default: begin
            mux_nib = disp_o;
         end
      endcase
   end

   seg7_decoder u_dec (
      .hex (mux_nib),
      .seg (dec_seg)
   );

   always_comb begin
      seg_next = dec_seg;
      if (!disp_valid) begin
         seg_next = SEG_DASH;
      end else if (mux_blank) begin
         seg_next = SEG_BLANK;
      end
   end

   // Anode, cathodes and dp share one register stage so they switch together.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         seg <= SEG_BLANK;
         an  <= 4'b1111;
         dp  <= 1'b1;
      end else begin
         seg <= seg_next;
         an  <= ~(4'b0001 << dig_idx);
         dp  <= disp_valid ? mux_dp : 1'b1;
      end
   end

endmodule

// File: tb/tb_sqrt_display.sv
module tb_sqrt_display;

   localparam logic [6:0] G_0     = 7'b1000000;
   localparam logic [6:0] G_1     = 7'b1111001;
   localparam logic [6:0] G_2     = 7'b0100100;
   localparam logic [6:0] G_3     = 7'b0110000;
   localparam logic [6:0] G_5     = 7'b0010010;
   localparam logic [6:0] G_9     = 7'b0010000;
   localparam logic [6:0] G_A     = 7'b0001000;
   localparam logic [6:0] G_E     = 7'b0000110;
   localparam logic [6:0] G_F     = 7'b0001110;
   localparam logic [6:0] G_DASH  = 7'b0111111;
   localparam logic [6:0] G_BLANK = 7'b1111111;

   logic       clk;
   logic       clr;
   logic       done;
   logic [3:0] sqrt;
   logic [7:0] a;
   logic [6:0] seg;
   logic [3:0] an;
   logic       dp;
   logic       busy;

   int vectors;
   int miscompares;

   sqrt_display #(.DIGIT_CYCLES(4)) dut (
      .clk  (clk),
      .clr  (clr),
      .done (done),
      .sqrt (sqrt),
      .a    (a),
      .seg  (seg),
      .an   (an),
      .dp   (dp),
      .busy (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) for a given anode to be active and sample it.
   task automatic get_digit(input logic [3:0] want, output logic [6:0] s,
                            output logic d, output logic found);
      found = 1'b0;
      s     = 7'bx;
      d     = 1'bx;
      for (int i = 0; i < 24 && !found; i++) begin
         @(negedge clk);
         if (an === want) begin
            found = 1'b1;
            s     = seg;
            d     = dp;
         end
      end
   endtask

   task automatic read_display(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                               input logic [6:0] e1, input logic [6:0] e0);
      logic [6:0] s;
      logic       d;
      logic       f;
      logic [6:0] exp_s [4];
      exp_s[0] = e0; exp_s[1] = e1; exp_s[2] = e2; exp_s[3] = e3;
      for (int k = 3; k >= 0; k--) begin
         get_digit(~(4'b0001 << k), s, d, f);
         chk($sformatf("%s_found%0d", tag, k), {31'd0, f}, 32'd1);
         chk($sformatf("%s_seg%0d", tag, k), {25'd0, s}, {25'd0, exp_s[k]});
         chk($sformatf("%s_dp%0d", tag, k), {31'd0, d}, (k == 3) ? 32'd0 : 32'd1);
      end
   endtask

   // Pulse done for one cycle and allow the conversion to finish.
   task automatic convert(input logic [7:0] av, input logic [3:0] sv);
      @(negedge clk);
      done = 1'b0;
      a    = av;
      sqrt = sv;
      @(negedge clk);
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      repeat (14) @(negedge clk);
   endtask

   // Expected pattern for the 255 / F display, by active anode.
   function automatic logic [6:0] old_seg(input logic [3:0] anv);
      case (anv)
         4'b0111: return G_F;
         4'b1011: return G_2;
         4'b1101: return G_5;
         4'b1110: return G_5;
         default: return 7'bx;
      endcase
   endfunction

   initial begin
      int busy_cnt;
      vectors     = 0;
      miscompares = 0;
      clr  = 1'b0;
      done = 1'b0;
      a    = 8'd0;
      sqrt = 4'd0;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_an",   {28'd0, an},  32'hF);
      chk("rst_seg",  {25'd0, seg}, {25'd0, G_BLANK});
      chk("rst_dp",   {31'd0, dp},  32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);

      // dash scan after release: 4 clocks per digit
      clr = 1'b1;
      for (int e = 1; e <= 16; e++) begin
         logic [3:0] ea;
         @(negedge clk);
         ea = ~(4'b0001 << ((e - 1) / 4));
         chk($sformatf("scan_an_%0d", e), {28'd0, an}, {28'd0, ea});
         chk($sformatf("scan_seg_%0d", e), {25'd0, seg}, {25'd0, G_DASH});
      end
      chk("scan_dp",   {31'd0, dp},   32'd1);
      chk("scan_busy", {31'd0, busy}, 32'd0);

      // a=200 sqrt=14: busy exactly 9 cycles
      a    = 8'd200;
      sqrt = 4'd14;
      done = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         if (i == 0) done = 1'b0;
         chk($sformatf("busy200_%0d", i), {31'd0, busy}, 32'd1);
         if (i == 4) chk("conv_dash", {25'd0, seg}, {25'd0, G_DASH});
         @(posedge clk);
      end
      @(negedge clk);
      chk("busy200_end", {31'd0, busy}, 32'd0);
      repeat (2) @(negedge clk);
      read_display("d200", G_E, G_2, G_0, G_0);

      // blanking
      convert(8'd9, 4'd3);
      read_display("d9", G_3, G_BLANK, G_BLANK, G_9);
      convert(8'd0, 4'd0);
      read_display("d0", G_0, G_BLANK, G_BLANK, G_0);

      // done held high 50 cycles -> one conversion
      @(negedge clk);
      a    = 8'd255;
      sqrt = 4'd15;
      done = 1'b1;
      busy_cnt = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
      end
      done = 1'b0;
      chk("held_busy_cycles", busy_cnt, 32'd9);
      repeat (4) @(negedge clk);
      read_display("d255", G_F, G_2, G_5, G_5);

      // second edge during CONV ignored; old display visible until commit
      @(negedge clk);
      a    = 8'd100;
      sqrt = 4'd10;
      done = 1'b1;
      @(posedge clk);
      @(negedge clk);
      done = 1'b0;
      chk("ign_old_a", {25'd0, seg}, {25'd0, old_seg(an)});
      @(negedge clk);
      a    = 8'd50;
      sqrt = 4'd7;
      done = 1'b1;
      chk("ign_old_b", {25'd0, seg}, {25'd0, old_seg(an)});
      @(negedge clk);
      done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("ign_old_%0d", i), {25'd0, seg}, {25'd0, old_seg(an)});
      end
      repeat (12) @(negedge clk);
      chk("ign_not_queued", {31'd0, busy}, 32'd0);
      read_display("d100", G_A, G_1, G_0, G_0);
      chk("ign_still_idle", {31'd0, busy}, 32'd0);

      // reset mid-conversion
      @(negedge clk);
      a    = 8'd77;
      sqrt = 4'd8;
      done = 1'b1;
      @(posedge clk);
      @(negedge clk);
      done = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_busy", {31'd0, busy}, 32'd1);
      clr = 1'b0;
      #1;
      chk("mid_rst_an",   {28'd0, an},   32'hF);
      chk("mid_rst_seg",  {25'd0, seg},  {25'd0, G_BLANK});
      chk("mid_rst_dp",   {31'd0, dp},   32'd1);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      repeat (2) @(negedge clk);
      chk("mid_hold_an",  {28'd0, an},  32'hF);
      clr = 1'b1;
      @(negedge clk);
      chk("mid_rel_an",  {28'd0, an},  32'hE);
      chk("mid_rel_seg", {25'd0, seg}, {25'd0, G_DASH});
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         chk($sformatf("mid_dash_%0d", i), {25'd0, seg}, {25'd0, G_DASH});
      end
      chk("mid_dp",   {31'd0, dp},   32'd1);
      chk("mid_busy_end", {31'd0, busy}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
